// File: rtl/window_3x3_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_gen_pkg
// Description : Shared defaults, state encoding and width helper for the
//               3x3 window generator.
// Revision    : 1.0 - initial release
// ============================================================================
package window_3x3_gen_pkg;

    localparam int unsigned c_pix_w_def = 4;
    localparam int unsigned c_img_w_def = 64;
    localparam int unsigned c_img_h_def = 64;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Width of a counter that spans 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_3x3_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_gen_if
// Description : Pixel stream in / 3x3 window out bundle for window_3x3_gen.
// Revision    : 1.0 - initial release
// ============================================================================
interface window_3x3_gen_if #(
    parameter int unsigned PIX_W = window_3x3_gen_pkg::c_pix_w_def,
    parameter int unsigned IMG_W = window_3x3_gen_pkg::c_img_w_def,
    parameter int unsigned IMG_H = window_3x3_gen_pkg::c_img_h_def
);
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             sof;
    logic [PIX_W-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic             win_valid;
    logic [window_3x3_gen_pkg::cnt_w(IMG_H)-1:0] win_row;
    logic [window_3x3_gen_pkg::cnt_w(IMG_W)-1:0] win_col;
    logic             frame_done;

    modport master (
        output pix_in, pix_valid, sof,
        input  p1, p2, p3, p4, p5, p6, p7, p8, p9,
        input  win_valid, win_row, win_col, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output p1, p2, p3, p4, p5, p6, p7, p8, p9,
        output win_valid, win_row, win_col, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/window_3x3_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_gen_line_buffer
// Description : One-row pixel store, combinational read and clocked write at
//               the same address, so a read returns the pre-write contents.
// Revision    : 1.0 - initial release
// ============================================================================
module window_3x3_gen_line_buffer #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] addr,
    input  wire logic [WIDTH-1:0]  wr_data,
    output logic      [WIDTH-1:0]  rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign rd_data = r_mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[addr] <= wr_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_gen
// Description : Streaming 3x3 neighbourhood generator; emits one registered
//               window per interior centre pixel of a raster-order frame.
// Revision    : 1.0 - initial release
// ============================================================================
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int unsigned PIX_W = c_pix_w_def,
    parameter int unsigned IMG_W = c_img_w_def,
    parameter int unsigned IMG_H = c_img_h_def
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    window_3x3_gen_if.slave bus
);
    localparam int unsigned ROW_W = cnt_w(IMG_H);
    localparam int unsigned COL_W = cnt_w(IMG_W);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);

    state_t           r_state, w_state_next;
    logic [ROW_W-1:0] r_row, w_row, w_row_next;
    logic [COL_W-1:0] r_col, w_col, w_col_next;
    logic             w_accept, w_last, w_fire;
    logic [PIX_W-1:0] w_lb0_rd, w_lb1_rd;
    logic [PIX_W-1:0] w_new [3];
    logic [PIX_W-1:0] r_col_a [3];
    logic [PIX_W-1:0] r_col_b [3];
    logic [PIX_W-1:0] r_p [9];
    logic             r_win_valid, r_frame_done;
    logic [ROW_W-1:0] r_win_row;
    logic [COL_W-1:0] r_win_col;

    // sof restarts at (0,0) regardless of state.
    assign w_accept = bus.pix_valid && (bus.sof || (r_state == ST_RUN));
    assign w_row    = bus.sof ? '0 : r_row;
    assign w_col    = bus.sof ? '0 : r_col;
    assign w_last   = (w_row == c_row_last) && (w_col == c_col_last);
    assign w_fire   = w_accept && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));

    window_3x3_gen_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (w_accept),
        .addr    (w_col),
        .wr_data (bus.pix_in),
        .rd_data (w_lb0_rd)
    );

    window_3x3_gen_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .ADDR_W(COL_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (w_accept),
        .addr    (w_col),
        .wr_data (w_lb0_rd),
        .rd_data (w_lb1_rd)
    );

    assign w_new[0] = w_lb1_rd;
    assign w_new[1] = w_lb0_rd;
    assign w_new[2] = bus.pix_in;

    always_comb begin
        w_state_next = r_state;
        w_row_next   = r_row;
        w_col_next   = r_col;
        if (w_accept) begin
            if (w_last) begin
                w_state_next = ST_IDLE;
                w_row_next   = '0;
                w_col_next   = '0;
            end else begin
                w_state_next = ST_RUN;
                if (w_col == c_col_last) begin
                    w_col_next = '0;
                    w_row_next = w_row + ROW_W'(1);
                end else begin
                    w_col_next = w_col + COL_W'(1);
                    w_row_next = w_row;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_next;
            r_row   <= w_row_next;
            r_col   <= w_col_next;
        end
    end

    // r_col_a/r_col_b hold columns c-1 and c; outputs load only on a valid window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                r_col_a[k] <= '0;
                r_col_b[k] <= '0;
            end
            for (int i = 0; i < 9; i++) begin
                r_p[i] <= '0;
            end
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
        end else begin
            r_win_valid  <= w_fire;
            r_frame_done <= w_accept && w_last;
            if (w_accept) begin
                for (int k = 0; k < 3; k++) begin
                    r_col_a[k] <= r_col_b[k];
                    r_col_b[k] <= w_new[k];
                end
            end
            if (w_fire) begin
                for (int k = 0; k < 3; k++) begin
                    r_p[3*k]     <= r_col_a[k];
                    r_p[3*k + 1] <= r_col_b[k];
                    r_p[3*k + 2] <= w_new[k];
                end
                r_win_row <= w_row - ROW_W'(1);
                r_win_col <= w_col - COL_W'(1);
            end
        end
    end

    assign bus.p1         = r_p[0];
    assign bus.p2         = r_p[1];
    assign bus.p3         = r_p[2];
    assign bus.p4         = r_p[3];
    assign bus.p5         = r_p[4];
    assign bus.p6         = r_p[5];
    assign bus.p7         = r_p[6];
    assign bus.p8         = r_p[7];
    assign bus.p9         = r_p[8];
    assign bus.win_valid  = r_win_valid;
    assign bus.win_row    = r_win_row;
    assign bus.win_col    = r_win_col;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Streaming 3x3 neighbourhood generator for the Gaussian-blur path. It sits directly upstream of the 3x3 averaging stage.
- Accepts raster-order pixels, one per valid cycle. Uses two line buffers plus a 3x3 shift-register window.
- Presents nine registered pixels p1..p9 with a valid strobe for every interior centre pixel. Border pixels produce no window.

Parameters:
- PIX_W, 4, pixel width in bits.
- IMG_W, 64, image width in pixels (>=3).
- IMG_H, 64, image height in pixels (>=3).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pix_in  input  PIX_W  incoming pixel, raster order.
- pix_valid  input  1  pix_in accepted this cycle. No backpressure; gaps allowed.
- sof  input  1  start-of-frame. Qualified by pix_valid; marks pixel (0,0).
- p1..p9  output  PIX_W each  window, row-major. p1 is top-left, p5 is centre, p9 is bottom-right.
- win_valid  output  1  p1..p9, win_row and win_col are valid this cycle.
- win_row  output  $clog2(IMG_H)  row of centre pixel p5.
- win_col  output  $clog2(IMG_W)  column of centre pixel p5.
- frame_done  output  1  one-cycle pulse, coincident with the last win_valid of a frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs go to 0.
  - Row/col counters go to 0; state goes to IDLE.
  - Line-buffer contents are don't-care.
- States:
  - IDLE: pixel_valid without sof is dropped, with no state change. pix_valid&sof accepts the pixel as (0,0) and moves to RUN.
  - RUN: each pix_valid accepts the pixel at the current (r,c). Then c increments; at c=IMG_W-1, c wraps to 0 and r increments.
  - RUN: the accepted pixel (IMG_H-1, IMG_W-1) returns the block to IDLE.
  - RUN: pix_valid&sof restarts the frame. The pixel is taken as (0,0), the state stays RUN, and the old frame is abandoned with no frame_done.
- Line buffers: lb0 holds row r-1, lb1 holds row r-2, both indexed by column, read-before-write. On accepting pixel x at (r,c):
  - lb1[c] <= lb0[c];
  - lb0[c] <= x;
  - the old lb1[c] and old lb0[c] feed the window.
- Window:
  - On each accepted pixel, the window columns shift left. The new right column is {old lb1[c], old lb0[c], x}, top to bottom.
  - The window holds when pix_valid=0.
- Output timing and values:
  - win_valid=1 in the cycle after accepting (r,c) with r>=2 and c>=2.
  - p1..p9 are then rows r-2..r and columns c-2..c; win_row=r-1, win_col=c-1.
  - Latency is 1 cycle from the accepting edge to the registered outputs.
  - win_valid is 0 otherwise. p1..p9 hold their last value when win_valid=0.
- Windows per frame: (IMG_W-2)*(IMG_H-2).
- frame_done pulses with the window for accepted pixel (IMG_H-1, IMG_W-1).
- Stale row data from a previous row or frame never reaches a valid window, because validity requires r>=2 and c>=2.
- Arithmetic: counters are unsigned and wrap only at image bounds. Pixel data is passed through unmodified; this block does no arithmetic on pixel values.
- Pixels after frame end without sof are dropped (IDLE).

Decomposition:
- Shared package/header holds:
  - PIX_W, IMG_W and IMG_H defaults;
  - state encoding (IDLE=0, RUN=1);
  - the counter-width constants.
- Sub-module line_buffer:
  - Single-clock, one read/one write per cycle at the same address, read-before-write, depth IMG_W, width PIX_W.
  - Instantiated twice (lb0, lb1).

Test Plan:
- Bench configuration for all scenarios: IMG_W=5, IMG_H=4. Pixel value is (r*5+c) mod 16.
- Continuous frame with sof on (0,0) -> exactly 6 win_valid pulses.
  - First pulse: win_row=1, win_col=1, p1..p9 = 0,1,2,5,6,7,10,11,12.
  - Last pulse: win_row=2, win_col=3, p1..p9 = 7,8,9,12,13,14,1,2,3, with frame_done=1.
- Same frame with random 1-3 cycle gaps between pix_valid -> identical window sequence, each pulse 1 cycle after its accepting pixel.
- 7 pixels driven in IDLE without sof, then a normal frame -> no win_valid before the frame; the normal frame yields 6 correct windows.
- sof reasserted at (2,1) mid-frame, followed by a full frame -> no frame_done for the aborted frame; 6 correct windows for the new frame.
- rst_n pulsed low asynchronously mid-row 2 -> outputs 0 immediately; subsequent pixels without sof are ignored. A new sof frame produces 6 correct windows.
- Back-to-back frames, with sof on the cycle after the last pixel -> 12 windows and 2 frame_done pulses. The second frame's first window equals the first frame's.
